// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-through bypass and a
// per-register pending scoreboard for issue hazard tracking.
module regfile_mp_sb #(
  parameter int            DW       = 32,
  parameter int            AW       = 5,
  parameter int            NRD      = 2,
  parameter int            INIT_IDX = 25,
  parameter logic [DW-1:0] INIT_VAL = DW'(32'h40000010)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we0,
  input  logic [AW-1:0]     wa0,
  input  logic [DW-1:0]     wd0,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  input  logic [DW-1:0]     wd1,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              sb_set,
  input  logic [AW-1:0]     sb_addr,
  input  logic              flush
);

  localparam int NR = 1 << AW;

  if (NRD < 1 || NRD > 8 ||
      INIT_IDX < 0 || INIT_IDX >= NR) begin : g_bad_param
    $error("regfile_mp_sb: bad NRD or INIT_IDX");
  end

  logic [DW-1:0] mem [1:NR-1];
  logic [NR-1:1] busy;
  logic [NR-1:1] busy_nxt;
  logic          wc0;
  logic          wc1;

  assign wc0 = we0 && (wa0 != '0);
  assign wc1 = we1 && (wa1 != '0);

  // set beats a same-cycle commit clear; flush beats everything
  always_comb begin
    busy_nxt = busy;
    for (int r = 1; r < NR; r++) begin
      if (wc0 && wa0 == AW'(r))
        busy_nxt[r] = 1'b0;
      if (wc1 && wa1 == AW'(r))
        busy_nxt[r] = 1'b0;
      if (sb_set && sb_addr == AW'(r))
        busy_nxt[r] = 1'b1;
    end
    if (flush)
      busy_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 1; i < NR; i++)
        mem[i] <= (i == INIT_IDX) ? INIT_VAL : '0;
      busy <= '0;
    end else begin
      if (wc0)
        mem[wa0] <= wd0;
      if (wc1)
        mem[wa1] <= wd1;
      busy <= busy_nxt;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit0;
    logic          hit1;
    logic          nz;

    assign ra   = rd_addr[k*AW +: AW];
    assign nz   = (ra != '0);
    assign hit0 = we0 && (wa0 == ra);
    assign hit1 = we1 && (wa1 == ra);

    assign rd_data[k*DW +: DW] =
      !nz  ? '0  :
      hit1 ? wd1 :
      hit0 ? wd0 : mem[ra];

    assign rd_busy[k] =
      nz && !hit0 && !hit1 && busy[ra];
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: directed vector table plus
// randomized traffic against an array-based reference model.
module tb_regfile_mp_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NRD = 2;
  localparam int NR = 32;
  localparam logic [31:0] IV = 32'h40000010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              we0, we1;
  logic [AW-1:0]     wa0, wa1;
  logic [DW-1:0]     wd0, wd1;
  logic [AW-1:0]     ra0, ra1;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              sb_set;
  logic [AW-1:0]     sb_addr;
  logic              flush;

  assign rd_addr = {ra1, ra0};

  regfile_mp_sb #(
    .DW(DW), .AW(AW), .NRD(NRD),
    .INIT_IDX(25), .INIT_VAL(IV)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .flush(flush)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] m_regs [NR];
  bit          m_busy [NR];

  typedef struct {
    bit          rst_n;
    bit          we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    bit          we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    bit          sb_set;
    logic [4:0]  sb_addr;
    bit          flush;
    bit          chk;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    bit          e_b0;
    bit          e_b1;
  } vec_t;

  vec_t tbl [16];

  task automatic check(string nm,
                       logic [31:0] act,
                       logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  function automatic logic [31:0] exp_rd(
    logic [4:0] a);
    if (a == 0) return 0;
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
    return m_regs[a];
  endfunction

  function automatic logic exp_bz(logic [4:0] a);
    if (a == 0) return 0;
    if ((we0 && wa0 == a) || (we1 && wa1 == a))
      return 0;
    return m_busy[a];
  endfunction

  task automatic model_edge();
    if (!reset_n) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      foreach (m_busy[i]) m_busy[i] = 0;
      m_regs[25] = IV;
    end else begin
      if (we0 && wa0 != 0) begin
        m_regs[wa0] = wd0;
        m_busy[wa0] = 0;
      end
      if (we1 && wa1 != 0) begin
        m_regs[wa1] = wd1;
        m_busy[wa1] = 0;
      end
      if (sb_set && sb_addr != 0)
        m_busy[sb_addr] = 1;
      if (flush)
        foreach (m_busy[i]) m_busy[i] = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic apply(vec_t v);
    reset_n = v.rst_n;
    we0 = v.we0; wa0 = v.wa0; wd0 = v.wd0;
    we1 = v.we1; wa1 = v.wa1; wd1 = v.wd1;
    sb_set = v.sb_set; sb_addr = v.sb_addr;
    flush = v.flush;
    ra0 = v.ra0; ra1 = v.ra1;
  endtask

  task automatic idle();
    reset_n = 1; we0 = 0; we1 = 0;
    wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
    sb_set = 0; sb_addr = 0; flush = 0;
  endtask

  initial begin
    idle();
    ra0 = 0; ra1 = 0;
    reset_n = 0;
    @(negedge clk);
    cycle();
    cycle();
    reset_n = 1;

    // rst we0 wa0 wd0 we1 wa1 wd1 set sa fl chk ra0 ra1 d0 d1 b0 b1
    tbl[0]  = '{1,0,0,0,0,0,0,0,0,0,1,25,3,IV,0,0,0};
    tbl[1]  = '{1,1,7,32'hA5A5A5A5,0,0,0,0,0,0,1,
                7,0,32'hA5A5A5A5,0,0,0};
    tbl[2]  = '{1,0,0,0,0,0,0,0,0,0,1,
                7,7,32'hA5A5A5A5,32'hA5A5A5A5,0,0};
    tbl[3]  = '{1,1,9,1,1,9,2,0,0,0,1,9,9,2,2,0,0};
    tbl[4]  = '{1,1,0,32'hFFFFFFFF,0,0,0,0,0,0,1,
                9,0,2,0,0,0};
    tbl[5]  = '{1,0,0,0,0,0,0,0,0,0,1,0,9,0,2,0,0};
    tbl[6]  = '{1,0,0,0,0,0,0,1,12,0,1,12,0,0,0,0,0};
    tbl[7]  = '{1,0,0,0,1,12,32'h55,0,0,0,1,
                12,12,32'h55,32'h55,0,0};
    tbl[8]  = '{1,0,0,0,0,0,0,0,0,0,1,12,0,32'h55,0,0,0};
    tbl[9]  = '{1,1,12,32'h66,0,0,0,1,12,0,1,
                12,0,32'h66,0,0,0};
    tbl[10] = '{1,0,0,0,0,0,0,0,0,0,1,12,0,32'h66,0,1,0};
    tbl[11] = '{1,0,0,0,0,0,0,1,5,1,1,12,5,32'h66,0,1,0};
    tbl[12] = '{1,0,0,0,0,0,0,0,0,0,1,12,5,32'h66,0,0,0};
    tbl[13] = '{0,1,4,32'h1234,0,0,0,1,4,0,0,4,25,0,0,0,0};
    tbl[14] = '{1,0,0,0,0,0,0,0,0,0,1,4,25,0,IV,0,0};
    tbl[15] = '{1,0,0,0,0,0,0,0,0,0,1,7,9,0,0,0,0};

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i]);
      #1;
      if (tbl[i].chk) begin
        check($sformatf("vec%0d_d0", i),
              rd_data[31:0], tbl[i].e_d0);
        check($sformatf("vec%0d_d1", i),
              rd_data[63:32], tbl[i].e_d1);
        check($sformatf("vec%0d_b0", i),
              32'(rd_busy[0]), 32'(tbl[i].e_b0));
        check($sformatf("vec%0d_b1", i),
              32'(rd_busy[1]), 32'(tbl[i].e_b1));
      end
      cycle();
    end

    // hand sequence: set/clear race across both ports
    idle();
    sb_set = 1; sb_addr = 20;
    ra0 = 20; ra1 = 0;
    cycle();
    idle();
    we0 = 1; wa0 = 20; wd0 = 32'hAB;
    we1 = 1; wa1 = 21; wd1 = 32'hCD;
    sb_set = 1; sb_addr = 21;
    ra0 = 20; ra1 = 21;
    #1;
    check("race_b0", 32'(rd_busy[0]), 0);
    check("race_d1", rd_data[63:32], 32'hCD);
    cycle();
    idle();
    #1;
    check("race_after_b0", 32'(rd_busy[0]), 0);
    check("race_after_b1", 32'(rd_busy[1]), 1);
    check("race_after_d0", rd_data[31:0], 32'hAB);

    for (int n = 0; n < 400; n++) begin
      bit nar;
      nar = ($urandom_range(0, 1) == 1);
      reset_n = ($urandom_range(0, 39) != 0);
      we0 = $urandom_range(0, 1);
      we1 = $urandom_range(0, 1);
      wa0 = nar ? 5'($urandom_range(0, 7))
                : 5'($urandom);
      wa1 = nar ? 5'($urandom_range(0, 7))
                : 5'($urandom);
      wd0 = $urandom;
      wd1 = $urandom;
      sb_set = ($urandom_range(0, 2) != 0);
      sb_addr = nar ? 5'($urandom_range(0, 7))
                    : 5'($urandom);
      flush = ($urandom_range(0, 19) == 0);
      ra0 = nar ? 5'($urandom_range(0, 7))
                : 5'($urandom);
      ra1 = ($urandom_range(0, 3) == 0) ? ra0
            : 5'($urandom_range(0, 7));
      #1;
      if (reset_n) begin
        check("rnd_d0", rd_data[31:0], exp_rd(ra0));
        check("rnd_d1", rd_data[63:32], exp_rd(ra1));
        check("rnd_b0", 32'(rd_busy[0]),
              32'(exp_bz(ra0)));
        check("rnd_b1", 32'(rd_busy[1]),
              32'(exp_bz(ra1)));
      end
      cycle();
    end

    // sweep every address against the model
    idle();
    for (int a = 0; a < NR; a++) begin
      ra0 = 5'(a);
      ra1 = 5'(NR - 1 - a);
      #1;
      check("sweep_d0", rd_data[31:0], exp_rd(ra0));
      check("sweep_b1", 32'(rd_busy[1]),
            32'(exp_bz(ra1)));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
